// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_pkg
// Brief  : Shared state encoding and 100 MHz default timing for the button path.
// Rev    : 1.0  initial release
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned c_debounce_default = 1_000_000;    // 10 ms
  localparam int unsigned c_long_default     = 100_000_000;  // 1 s
  localparam int unsigned c_cnt_w_default    = 32;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : sync_2ff
// Brief  : 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  logic i_w_clk,
  input  logic i_w_reset,
  input  logic i_w_d,
  output logic o_r_q
);

  logic r_meta;

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_meta <= 1'b0;
      o_r_q  <= 1'b0;
    end else begin
      r_meta <= i_w_d;
      o_r_q  <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : button_conditioner
// Brief  : Debounces a raw push-button into level, press/release/long pulses
//          and a wrapping press counter.
// Rev    : 1.0  initial release
// ============================================================================
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_default,
  parameter int unsigned LONG_CYCLES     = c_long_default,
  parameter int unsigned CNT_W           = c_cnt_w_default
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_button,
  output logic       o_r_level,
  output logic       o_r_press,
  output logic       o_r_release,
  output logic       o_r_long,
  output logic [7:0] o_r_press_count
);

  localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_max  = CNT_W'(LONG_CYCLES);

  logic w_rst_n;
  logic w_in;

  // Reset asserts immediately but releases on a clock edge.
  sync_2ff u_rst_sync (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_d     (1'b1),
    .o_r_q     (w_rst_n)
  );

  sync_2ff u_btn_sync (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_d     (i_w_button),
    .o_r_q     (w_in)
  );

  btn_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_dcnt, w_dcnt_next, w_dcnt_inc;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_next;
  logic             r_long_done, w_long_done_next;
  logic             w_level_next, w_press_next, w_release_next, w_long_next;
  logic [7:0]       w_count_next;

  assign w_dcnt_inc = r_dcnt + CNT_W'(1);

  always_ff @(posedge i_w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state         <= IDLE;
      r_dcnt          <= '0;
      r_hcnt          <= '0;
      r_long_done     <= 1'b0;
      o_r_level       <= 1'b0;
      o_r_press       <= 1'b0;
      o_r_release     <= 1'b0;
      o_r_long        <= 1'b0;
      o_r_press_count <= 8'd0;
    end else begin
      r_state         <= w_state_next;
      r_dcnt          <= w_dcnt_next;
      r_hcnt          <= w_hcnt_next;
      r_long_done     <= w_long_done_next;
      o_r_level       <= w_level_next;
      o_r_press       <= w_press_next;
      o_r_release     <= w_release_next;
      o_r_long        <= w_long_next;
      o_r_press_count <= w_count_next;
    end
  end

  // Acceptance fires on the edge where dcnt reaches DEBOUNCE_CYCLES-1, so the
  // registered pulse appears in the same cycle the count completes.
  always_comb begin
    w_state_next     = r_state;
    w_dcnt_next      = r_dcnt;
    w_hcnt_next      = r_hcnt;
    w_long_done_next = r_long_done;
    w_level_next     = o_r_level;
    w_press_next     = 1'b0;
    w_release_next   = 1'b0;
    w_long_next      = 1'b0;
    w_count_next     = o_r_press_count;

    case (r_state)
      IDLE: begin
        if (w_in) begin
          w_state_next = PRESS_WAIT;
          w_dcnt_next  = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_in) begin
          w_state_next = IDLE;
          w_dcnt_next  = '0;
        end else if (w_dcnt_inc == c_db_last) begin
          w_state_next     = HELD;
          w_dcnt_next      = '0;
          w_hcnt_next      = '0;
          w_long_done_next = 1'b0;
          w_press_next     = 1'b1;
          w_level_next     = 1'b1;
          w_count_next     = o_r_press_count + 8'd1;
        end else begin
          w_dcnt_next = w_dcnt_inc;
        end
      end

      HELD: begin
        if (r_hcnt != c_long_max) w_hcnt_next = r_hcnt + CNT_W'(1);
        if ((r_hcnt == c_long_last) && !r_long_done) begin
          w_long_next      = 1'b1;
          w_long_done_next = 1'b1;
        end
        if (!w_in) begin
          w_state_next = RELEASE_WAIT;
          w_dcnt_next  = '0;
        end
      end

      RELEASE_WAIT: begin
        // Hold time is frozen here so a short dip only delays the long press.
        if (w_in) begin
          w_state_next = HELD;
          w_dcnt_next  = '0;
        end else if (w_dcnt_inc == c_db_last) begin
          w_state_next   = IDLE;
          w_dcnt_next    = '0;
          w_release_next = 1'b1;
          w_level_next   = 1'b0;
        end else begin
          w_dcnt_next = w_dcnt_inc;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_dcnt_next  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : tb_button_conditioner
// Brief  : Directed self-checking bench, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Rev    : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic       level, press, release_p, long_p;
  logic [7:0] count;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .CNT_W           (32)
  ) dut (
    .i_w_clk         (clk),
    .i_w_reset       (rst_n),
    .i_w_button      (button),
    .o_r_level       (level),
    .o_r_press       (press),
    .o_r_release     (release_p),
    .o_r_long        (long_p),
    .o_r_press_count (count)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_press = 0, n_rel = 0, n_long = 0, n_level = 0, n_both = 0;
  int t_press = 0, t_rel = 0, t_long = 0;
  always @(negedge clk) begin
    if (press)     begin n_press++; t_press = cyc; end
    if (release_p) begin n_rel++;   t_rel   = cyc; end
    if (long_p)    begin n_long++;  t_long  = cyc; end
    if (level)     n_level++;
    if (press && release_p) n_both++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    button = 1'b0;
    tick(3);
    checks++; if (level !== 1'b0)     begin errors++; $display("FAIL reset_level: got %b want 0", level); end
    checks++; if (press !== 1'b0)     begin errors++; $display("FAIL reset_press: got %b want 0", press); end
    checks++; if (release_p !== 1'b0) begin errors++; $display("FAIL reset_release: got %b want 0", release_p); end
    checks++; if (long_p !== 1'b0)    begin errors++; $display("FAIL reset_long: got %b want 0", long_p); end
    checks++; if (count !== 8'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_clean_press();
    int t0, t1, bp, br, bl, bv;
    bp = n_press; br = n_rel; bl = n_long; bv = n_level;
    t0 = cyc; button = 1'b1; tick(10);
    t1 = cyc; button = 1'b0; tick(12);
    checks++; if (n_press - bp != 1)  begin errors++; $display("FAIL clean_press_n: got %0d want 1", n_press - bp); end
    checks++; if (t_press - t0 != 6)  begin errors++; $display("FAIL clean_press_lat: got %0d want 6", t_press - t0); end
    checks++; if (n_rel - br != 1)    begin errors++; $display("FAIL clean_rel_n: got %0d want 1", n_rel - br); end
    checks++; if (t_rel - t1 != 6)    begin errors++; $display("FAIL clean_rel_lat: got %0d want 6", t_rel - t1); end
    checks++; if (n_level - bv != 10) begin errors++; $display("FAIL clean_level_len: got %0d want 10", n_level - bv); end
    checks++; if (n_long - bl != 0)   begin errors++; $display("FAIL clean_no_long: got %0d want 0", n_long - bl); end
    checks++; if (count !== 8'd1)     begin errors++; $display("FAIL clean_count: got %0d want 1", count); end
    checks++; if (level !== 1'b0)     begin errors++; $display("FAIL clean_level_end: got %b want 0", level); end
  endtask

  task automatic test_bounce();
    int t0, bp, br;
    bp = n_press; br = n_rel;
    button = 1'b1; tick(1); button = 1'b0; tick(1);
    button = 1'b1; tick(1); button = 1'b0; tick(1);
    t0 = cyc; button = 1'b1; tick(12);
    button = 1'b0; tick(12);
    checks++; if (n_press - bp != 1) begin errors++; $display("FAIL bounce_press_n: got %0d want 1", n_press - bp); end
    checks++; if (t_press - t0 != 6) begin errors++; $display("FAIL bounce_press_lat: got %0d want 6", t_press - t0); end
    checks++; if (n_rel - br != 1)   begin errors++; $display("FAIL bounce_rel_n: got %0d want 1", n_rel - br); end
    checks++; if (count !== 8'd2)    begin errors++; $display("FAIL bounce_count: got %0d want 2", count); end
  endtask

  task automatic test_long();
    int t0, t1, bl, br;
    bl = n_long; br = n_rel;
    t0 = cyc; button = 1'b1; tick(40);
    t1 = cyc; button = 1'b0; tick(12);
    checks++; if (n_long - bl != 1)       begin errors++; $display("FAIL long_n: got %0d want 1", n_long - bl); end
    checks++; if (t_press - t0 != 6)      begin errors++; $display("FAIL long_press_lat: got %0d want 6", t_press - t0); end
    checks++; if (t_long - t_press != 16) begin errors++; $display("FAIL long_lat: got %0d want 16", t_long - t_press); end
    checks++; if (n_rel - br != 1)        begin errors++; $display("FAIL long_rel_n: got %0d want 1", n_rel - br); end
    checks++; if (t_rel - t1 != 6)        begin errors++; $display("FAIL long_rel_lat: got %0d want 6", t_rel - t1); end
    checks++; if (count !== 8'd3)         begin errors++; $display("FAIL long_count: got %0d want 3", count); end
  endtask

  task automatic test_dip();
    int bp, br, bl;
    bp = n_press; br = n_rel; bl = n_long;
    button = 1'b1; tick(10);
    button = 1'b0; tick(2);
    button = 1'b1; tick(30);
    button = 1'b0; tick(12);
    checks++; if (n_press - bp != 1)      begin errors++; $display("FAIL dip_press_n: got %0d want 1", n_press - bp); end
    checks++; if (n_rel - br != 1)        begin errors++; $display("FAIL dip_rel_n: got %0d want 1", n_rel - br); end
    checks++; if (n_long - bl != 1)       begin errors++; $display("FAIL dip_long_n: got %0d want 1", n_long - bl); end
    checks++; if (t_long - t_press != 18) begin errors++; $display("FAIL dip_long_lat: got %0d want 18", t_long - t_press); end
    checks++; if (count !== 8'd4)         begin errors++; $display("FAIL dip_count: got %0d want 4", count); end
  endtask

  task automatic test_glitch();
    int bp, br, bv;
    bp = n_press; bv = n_level;
    button = 1'b1; tick(3);
    button = 1'b0; tick(10);
    checks++; if (n_press - bp != 0) begin errors++; $display("FAIL glitch_short_press: got %0d want 0", n_press - bp); end
    checks++; if (n_level - bv != 0) begin errors++; $display("FAIL glitch_short_level: got %0d want 0", n_level - bv); end
    bp = n_press; br = n_rel;
    button = 1'b1; tick(4);
    button = 1'b0; tick(12);
    checks++; if (n_press - bp != 1) begin errors++; $display("FAIL glitch_exact_press: got %0d want 1", n_press - bp); end
    checks++; if (n_rel - br != 1)   begin errors++; $display("FAIL glitch_exact_rel: got %0d want 1", n_rel - br); end
    bp = n_press; br = n_rel;
    button = 1'b1; tick(10);
    button = 1'b0; tick(3);
    button = 1'b1; tick(10);
    button = 1'b0; tick(12);
    checks++; if (n_press - bp != 1) begin errors++; $display("FAIL glitch_held_press: got %0d want 1", n_press - bp); end
    checks++; if (n_rel - br != 1)   begin errors++; $display("FAIL glitch_held_rel: got %0d want 1", n_rel - br); end
    checks++; if (count !== 8'd6)    begin errors++; $display("FAIL glitch_count: got %0d want 6", count); end
  endtask

  task automatic test_reset_mid();
    int t0, bp;
    button = 1'b1; tick(4);
    rst_n = 1'b0; #1;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL rst_pw_count: got %0d want 0", count); end
    checks++; if (press !== 1'b0) begin errors++; $display("FAIL rst_pw_press: got %b want 0", press); end
    tick(2);
    rst_n = 1'b1; t0 = cyc; bp = n_press;
    tick(10);
    checks++; if (n_press - bp != 1) begin errors++; $display("FAIL rst_pw_repress_n: got %0d want 1", n_press - bp); end
    checks++; if (t_press - t0 != 6) begin errors++; $display("FAIL rst_pw_repress_lat: got %0d want 6", t_press - t0); end
    checks++; if (level !== 1'b1)    begin errors++; $display("FAIL rst_held_level_pre: got %b want 1", level); end
    rst_n = 1'b0; #1;
    checks++; if (level !== 1'b0)    begin errors++; $display("FAIL rst_held_level: got %b want 0", level); end
    checks++; if (count !== 8'd0)    begin errors++; $display("FAIL rst_held_count: got %0d want 0", count); end
    tick(2);
    rst_n = 1'b1; t0 = cyc; bp = n_press;
    tick(10);
    checks++; if (n_press - bp != 1) begin errors++; $display("FAIL rst_held_repress_n: got %0d want 1", n_press - bp); end
    checks++; if (t_press - t0 != 6) begin errors++; $display("FAIL rst_held_repress_lat: got %0d want 6", t_press - t0); end
    checks++; if (count !== 8'd1)    begin errors++; $display("FAIL rst_held_recount: got %0d want 1", count); end
    button = 1'b0; tick(12);
  endtask

  task automatic test_wrap();
    int bp;
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(3);
    bp = n_press;
    for (int i = 0; i < 257; i++) begin
      button = 1'b1; tick(6);
      button = 1'b0; tick(8);
      if (i == 255) begin
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL wrap_256: got %0d want 0", count); end
      end
    end
    checks++; if (count !== 8'd1)      begin errors++; $display("FAIL wrap_257: got %0d want 1", count); end
    checks++; if (n_press - bp != 257) begin errors++; $display("FAIL wrap_press_n: got %0d want 257", n_press - bp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long();
    test_dip();
    test_glitch();
    test_reset_mid();
    test_wrap();
    checks++; if (n_both != 0) begin errors++; $display("FAIL press_and_release_overlap: got %0d want 0", n_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
